multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, using the 3-bit instruction class from TYPE_DECODER and the opcode held in the instruction register. It drives the IR, PC, register-file and memory strobes, performs the memory request/ready handshake with a bus timeout, and traps on illegal or SYSTEM instructions.

---
 rtl/multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer for the RV32I core: steps each instruction through
// fetch, decode, execute, memory and writeback, with a bus timeout and sticky traps.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_i,
    input  logic       mem_ready_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] decode_type_i,
    input  logic       branch_taken_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_is_fetch_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_sel_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic       bus_err_o,
    output logic       halt_o,
    output logic [2:0] state_o
);

    // Instruction class codes produced by TYPE_DECODER.
    localparam logic [2:0] T_NOP    = 3'd0;
    localparam logic [2:0] T_RTYPE  = 3'd1;
    localparam logic [2:0] T_ITYPE  = 3'd2;
    localparam logic [2:0] T_STYPE  = 3'd3;
    localparam logic [2:0] T_BTYPE  = 3'd4;
    localparam logic [2:0] T_UTYPE  = 3'd5;
    localparam logic [2:0] T_JTYPE  = 3'd6;
    localparam logic [2:0] T_SYSTEM = 3'd7;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, bus_err_q, halt_q;
    logic       set_illegal, set_bus_err, set_halt;

    logic       req_c, we_c, fetch_c, irw_c, pcw_c, regw_c, retire_c;
    logic [1:0] pcsel_c, wbsel_c;

    logic is_load, is_store, is_jalr, is_jtype, legal_op, is_known_type;

    assign is_load  = (decode_type_i == T_ITYPE) && (opcode_i == OP_LOAD);
    assign is_store = (decode_type_i == T_STYPE);
    assign is_jalr  = (opcode_i == OP_JALR);
    assign is_jtype = (decode_type_i == T_JTYPE);
    // Every RV32I encoding has opcode[1:0] = 11; anything else (e.g. all zeros)
    // is treated as outside the instruction-type set.
    assign legal_op = (opcode_i[1:0] == 2'b11);
    assign is_known_type = (decode_type_i == T_RTYPE) || (decode_type_i == T_ITYPE) ||
                           (decode_type_i == T_STYPE) || (decode_type_i == T_BTYPE) ||
                           (decode_type_i == T_UTYPE) || (decode_type_i == T_JTYPE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_q | set_illegal;
            bus_err_q <= bus_err_q | set_bus_err;
            halt_q    <= halt_q | set_halt;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        set_halt    = 1'b0;
        req_c       = 1'b0;
        we_c        = 1'b0;
        fetch_c     = 1'b0;
        irw_c       = 1'b0;
        pcw_c       = 1'b0;
        regw_c      = 1'b0;
        retire_c    = 1'b0;
        pcsel_c     = 2'b00;
        wbsel_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                req_c   = 1'b1;
                fetch_c = 1'b1;
                if (mem_ready_i) begin
                    irw_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_TRAP;
                    set_bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!stall_i) begin
                    if (decode_type_i == T_NOP) begin
                        pcw_c    = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else if (decode_type_i == T_SYSTEM) begin
                        state_d  = S_TRAP;
                        set_halt = 1'b1;
                    end else if (!legal_op || !is_known_type) begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (!stall_i) begin
                    if (decode_type_i == T_BTYPE) begin
                        pcw_c    = 1'b1;
                        pcsel_c  = branch_taken_i ? 2'b01 : 2'b00;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else if (is_store || is_load) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_MEM: begin
                req_c = 1'b1;
                we_c  = is_store;
                if (mem_ready_i) begin
                    if (is_store) begin
                        pcw_c    = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_TRAP;
                    set_bus_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                if (!stall_i) begin
                    regw_c   = 1'b1;
                    pcw_c    = 1'b1;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                    if (is_load) begin
                        wbsel_c = 2'b01;
                    end else if (is_jtype || is_jalr) begin
                        wbsel_c = 2'b10;
                    end
                    if (is_jtype) begin
                        pcsel_c = 2'b01;
                    end else if (is_jalr) begin
                        pcsel_c = 2'b10;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d     = S_TRAP;
                set_illegal = 1'b1;
            end
        endcase

        // Every entry to FETCH or MEM is a state change, so this restarts the timeout.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end
    end

    // Strobes are gated by the reset pin so they drop the instant reset is asserted.
    assign mem_req_o      = req_c & rst_n;
    assign mem_we_o       = we_c & rst_n;
    assign mem_is_fetch_o = fetch_c & rst_n;
    assign ir_write_o     = irw_c & rst_n;
    assign pc_write_o     = pcw_c & rst_n;
    assign reg_write_o    = regw_c & rst_n;
    assign retire_o       = retire_c & rst_n;
    assign pc_sel_o       = pcsel_c & {2{rst_n}};
    assign wb_sel_o       = wbsel_c & {2{rst_n}};
    assign illegal_o      = illegal_q;
    assign bus_err_o      = bus_err_q;
    assign halt_o         = halt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of per-cycle vectors covering every
// state path, plus hand-written CPI and asynchronous-reset sequences.
module tb_multicycle_ctrl;

    localparam logic [2:0] TY_NOP = 3'd0, TY_R = 3'd1, TY_I = 3'd2, TY_S = 3'd3;
    localparam logic [2:0] TY_B = 3'd4, TY_U = 3'd5, TY_J = 3'd6, TY_SYS = 3'd7;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_NOP  = 7'b0010011;
    localparam logic [6:0] OP_BAD  = 7'b0000000;

    // Strobe groups, ordered {req, we, fetch, irw, pcw, regw, retire}.
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_FW   = 7'b1010000;
    localparam logic [6:0] S_FR   = 7'b1011000;
    localparam logic [6:0] S_RET  = 7'b0000101;
    localparam logic [6:0] S_WB   = 7'b0000111;
    localparam logic [6:0] S_ML   = 7'b1000000;
    localparam logic [6:0] S_MS   = 7'b1100000;
    localparam logic [6:0] S_MSR  = 7'b1100101;

    // Trap flags, ordered {illegal, bus_err, halt}.
    localparam logic [2:0] T_NO = 3'b000, T_ILL = 3'b100, T_BUS = 3'b010, T_HLT = 3'b001;

    typedef struct {
        string      name;
        logic       rstn;
        logic       stall;
        logic       ready;
        logic [2:0] ty;
        logic [6:0] op;
        logic       tk;
        logic [2:0] st;
        logic [6:0] strb;
        logic [1:0] pcsel;
        logic [1:0] wbsel;
        logic [2:0] trap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] dtype = 3'd0;
    logic       taken = 1'b0;

    logic       mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write, retire;
    logic       illegal, bus_err, halt;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;

    vec_t vecs[$];
    int   nVec = 0;
    int   nErr = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .mem_ready_i    (ready),
        .opcode_i       (opcode),
        .decode_type_i  (dtype),
        .branch_taken_i (taken),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_is_fetch_o (mem_is_fetch),
        .ir_write_o     (ir_write),
        .pc_write_o     (pc_write),
        .pc_sel_o       (pc_sel),
        .reg_write_o    (reg_write),
        .wb_sel_o       (wb_sel),
        .retire_o       (retire),
        .illegal_o      (illegal),
        .bus_err_o      (bus_err),
        .halt_o         (halt),
        .state_o        (state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] actualOut();
        return {state, mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write, retire,
                pc_sel, wb_sel, illegal, bus_err, halt};
    endfunction

    task automatic add(input string name, input logic rstn, input logic stl, input logic rdy,
                       input logic [2:0] ty, input logic [6:0] op, input logic tk,
                       input logic [2:0] st, input logic [6:0] strb, input logic [1:0] pcs,
                       input logic [1:0] wbs, input logic [2:0] trap);
        vec_t v;
        v.name = name; v.rstn = rstn; v.stall = stl; v.ready = rdy; v.ty = ty; v.op = op;
        v.tk = tk; v.st = st; v.strb = strb; v.pcsel = pcs; v.wbsel = wbs; v.trap = trap;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst_n  = v.rstn;
        stall  = v.stall;
        ready  = v.ready;
        dtype  = v.ty;
        opcode = v.op;
        taken  = v.tk;
    endtask

    task automatic checkOutput(input string name, input logic [16:0] got, input logic [16:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got st=%0d strb=%b pcsel=%b wbsel=%b trap=%b, expected st=%0d strb=%b pcsel=%b wbsel=%b trap=%b",
                     name, got[16:14], got[13:7], got[6:5], got[4:3], got[2:0],
                     exp[16:14], exp[13:7], exp[6:5], exp[4:3], exp[2:0]);
        end
    endtask

    task automatic measureCpi(input string name, input logic [2:0] ty, input logic [6:0] op,
                              input int expCycles);
        int got;
        int c;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; ready = 1'b1; stall = 1'b0; dtype = ty; opcode = op; taken = 1'b0;
        got = 0;
        c = 1;
        while (got == 0 && c <= 20) begin
            @(negedge clk);
            if (retire === 1'b1) got = c;
            else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        nVec++;
        if (got != expCycles) begin
            nErr++;
            $display("[TB] FAIL cpi_%s: retire in cycle %0d, expected cycle %0d", name, got, expCycles);
        end
    endtask

    initial begin
        // Reset state
        add("reset",        0,0,0, TY_R,OP_R,0,    3'd0,S_NONE,2'b00,2'b00,T_NO);
        // R-type ADD, zero-wait
        add("add_fetch",    1,0,1, TY_R,OP_R,0,    3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("add_decode",   1,0,1, TY_R,OP_R,0,    3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("add_exec",     1,0,1, TY_R,OP_R,0,    3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("add_wb",       1,0,1, TY_R,OP_R,0,    3'd4,S_WB,  2'b00,2'b00,T_NO);
        // Load with 3 wait cycles; ready in the 4th MEM cycle hits the timeout boundary
        add("ld_fetch",     1,0,1, TY_I,OP_LOAD,0, 3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("ld_decode",    1,0,0, TY_I,OP_LOAD,0, 3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("ld_exec",      1,0,0, TY_I,OP_LOAD,0, 3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("ld_mem1",      1,0,0, TY_I,OP_LOAD,0, 3'd3,S_ML,  2'b00,2'b00,T_NO);
        add("ld_mem2",      1,0,0, TY_I,OP_LOAD,0, 3'd3,S_ML,  2'b00,2'b00,T_NO);
        add("ld_mem3",      1,0,0, TY_I,OP_LOAD,0, 3'd3,S_ML,  2'b00,2'b00,T_NO);
        add("ld_mem4",      1,0,1, TY_I,OP_LOAD,0, 3'd3,S_ML,  2'b00,2'b00,T_NO);
        add("ld_wb",        1,0,1, TY_I,OP_LOAD,0, 3'd4,S_WB,  2'b00,2'b01,T_NO);
        // BEQ taken then not taken
        add("beq1_fetch",   1,0,1, TY_B,OP_BR,1,   3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("beq1_decode",  1,0,1, TY_B,OP_BR,1,   3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("beq1_exec",    1,0,1, TY_B,OP_BR,1,   3'd2,S_RET, 2'b01,2'b00,T_NO);
        add("beq0_fetch",   1,0,1, TY_B,OP_BR,0,   3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("beq0_decode",  1,0,1, TY_B,OP_BR,0,   3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("beq0_exec",    1,0,1, TY_B,OP_BR,0,   3'd2,S_RET, 2'b00,2'b00,T_NO);
        // JALR and JAL
        add("jalr_fetch",   1,0,1, TY_I,OP_JALR,0, 3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("jalr_decode",  1,0,1, TY_I,OP_JALR,0, 3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("jalr_exec",    1,0,1, TY_I,OP_JALR,0, 3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("jalr_wb",      1,0,1, TY_I,OP_JALR,0, 3'd4,S_WB,  2'b10,2'b10,T_NO);
        add("jal_fetch",    1,0,1, TY_J,OP_JAL,0,  3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("jal_decode",   1,0,1, TY_J,OP_JAL,0,  3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("jal_exec",     1,0,1, TY_J,OP_JAL,0,  3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("jal_wb",       1,0,1, TY_J,OP_JAL,0,  3'd4,S_WB,  2'b01,2'b10,T_NO);
        // Store with one wait cycle
        add("st_fetch",     1,0,1, TY_S,OP_ST,0,   3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("st_decode",    1,0,0, TY_S,OP_ST,0,   3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("st_exec",      1,0,0, TY_S,OP_ST,0,   3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("st_mem_wait",  1,0,0, TY_S,OP_ST,0,   3'd3,S_MS,  2'b00,2'b00,T_NO);
        add("st_mem_done",  1,0,1, TY_S,OP_ST,0,   3'd3,S_MSR, 2'b00,2'b00,T_NO);
        // NOP
        add("nop_fetch",    1,0,1, TY_NOP,OP_NOP,0,3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("nop_decode",   1,0,1, TY_NOP,OP_NOP,0,3'd1,S_RET, 2'b00,2'b00,T_NO);
        // Stall ignored in FETCH, honoured for 3 cycles in EXEC of a taken branch
        add("stl_fetch",    1,1,1, TY_B,OP_BR,1,   3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("stl_decode",   1,0,1, TY_B,OP_BR,1,   3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("stl_exec1",    1,1,1, TY_B,OP_BR,1,   3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("stl_exec2",    1,1,1, TY_B,OP_BR,1,   3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("stl_exec3",    1,1,1, TY_B,OP_BR,1,   3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("stl_release",  1,0,1, TY_B,OP_BR,1,   3'd2,S_RET, 2'b01,2'b00,T_NO);
        // Reset pulsed during MEM
        add("rm_fetch",     1,0,1, TY_I,OP_LOAD,0, 3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("rm_decode",    1,0,0, TY_I,OP_LOAD,0, 3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("rm_exec",      1,0,0, TY_I,OP_LOAD,0, 3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("rm_mem",       1,0,0, TY_I,OP_LOAD,0, 3'd3,S_ML,  2'b00,2'b00,T_NO);
        add("rm_reset",     0,0,0, TY_I,OP_LOAD,0, 3'd0,S_NONE,2'b00,2'b00,T_NO);
        // Fetch ready in 4th cycle: no trap
        add("to4_c1",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("to4_c2",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("to4_c3",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("to4_c4_ready", 1,0,1, TY_R,OP_R,0,    3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("to4_decode",   1,0,0, TY_R,OP_R,0,    3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("to4_exec",     1,0,0, TY_R,OP_R,0,    3'd2,S_NONE,2'b00,2'b00,T_NO);
        add("to4_wb",       1,0,0, TY_R,OP_R,0,    3'd4,S_WB,  2'b00,2'b00,T_NO);
        // Fetch never ready: bus-error trap after 4 cycles
        add("tob_c1",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("tob_c2",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("tob_c3",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("tob_c4",       1,0,0, TY_R,OP_R,0,    3'd0,S_FW,  2'b00,2'b00,T_NO);
        add("tob_trap",     1,0,0, TY_R,OP_R,0,    3'd7,S_NONE,2'b00,2'b00,T_BUS);
        add("tob_hold",     1,0,1, TY_R,OP_R,0,    3'd7,S_NONE,2'b00,2'b00,T_BUS);
        add("tob_reset",    0,0,0, TY_R,OP_R,0,    3'd0,S_NONE,2'b00,2'b00,T_NO);
        // SYSTEM halts
        add("sys_fetch",    1,0,1, TY_SYS,OP_SYS,0,3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("sys_decode",   1,0,1, TY_SYS,OP_SYS,0,3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("sys_trap",     1,0,1, TY_SYS,OP_SYS,0,3'd7,S_NONE,2'b00,2'b00,T_HLT);
        add("sys_reset",    0,0,0, TY_SYS,OP_SYS,0,3'd0,S_NONE,2'b00,2'b00,T_NO);
        // Invalid opcode is illegal
        add("ill_fetch",    1,0,1, TY_R,OP_BAD,0,  3'd0,S_FR,  2'b00,2'b00,T_NO);
        add("ill_decode",   1,0,1, TY_R,OP_BAD,0,  3'd1,S_NONE,2'b00,2'b00,T_NO);
        add("ill_trap",     1,0,1, TY_R,OP_BAD,0,  3'd7,S_NONE,2'b00,2'b00,T_ILL);
        add("ill_reset",    0,0,0, TY_R,OP_BAD,0,  3'd0,S_NONE,2'b00,2'b00,T_NO);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i].name, actualOut(),
                        {vecs[i].st, vecs[i].strb, vecs[i].pcsel, vecs[i].wbsel, vecs[i].trap});
        end

        // Cycles per instruction with zero-wait memory
        measureCpi("nop",    TY_NOP, OP_NOP,  2);
        measureCpi("branch", TY_B,   OP_BR,   3);
        measureCpi("load",   TY_I,   OP_LOAD, 5);
        measureCpi("store",  TY_S,   OP_ST,   4);

        // Asserting reset mid-FETCH drops the request without waiting for a clock edge
        @(posedge clk);
        #1;
        checkOutput("fetch_before_reset", actualOut(),
                    {3'd0, S_FR, 2'b00, 2'b00, T_NO});
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", actualOut(), 17'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
